regfile_dump_reader: RTL and testbench
======================================

// Module: regfile_dump_reader
// PURPOSE
//  Sequential reader that walks the LC-3 register file through one read port and
//  streams the selected registers (index + value) over a valid/ready interface.
//  Sits beside the register file and owns one sr read-address port during a dump.
//  Consumers are the debug / hex-display / UART path.
//  Gives single-step and halt inspection without touching the datapath.
// PARAMETERS
//  NUM_REGS  8    number of architectural registers walked
//  DATA_W    16   register width
//  ADDR_W    3    register index width; must equal $clog2(NUM_REGS)
// PORTS
//  clk        in   1         system clock, rising edge
//  reset      in   1         asynchronous, active-low reset
//  start      in   1         dump request; sampled only in IDLE
//  abort      in   1         cancel dump in progress
//  mask       in   NUM_REGS  registers to dump, bit i = Ri; latched on accepted start
//  rd_addr    out  ADDR_W    to register-file read address (sr1/sr2)
//  rd_data    in   DATA_W    combinational read data for rd_addr
//  out_valid  out  1         beat valid
//  out_ready  in   1         consumer accepts beat
//  out_index  out  ADDR_W    register index of the current beat
//  out_data   out  DATA_W    register value of the current beat
//  out_last   out  1         current beat is the final one of the dump
//  busy       out  1         high in every state except IDLE
//  done       out  1         one-cycle pulse when a dump completes normally
// BEHAVIOUR
//  - Reset (async, reset==0): state=IDLE; mask_q=0, ptr=0, rd_addr=0, out_valid=0,
//    out_index=0, out_data=0, out_last=0, busy=0, done=0.
//  - FSM states: IDLE, SCAN, HOLD, DONE.
//  - IDLE:
//    - start=1 with mask!=0: latch mask_q; ptr = lowest set bit of mask; go to SCAN.
//    - start=1 with mask==0: go to DONE; no beats are produced.
//  - SCAN: rd_addr=ptr. At the next edge:
//    - out_data<=rd_data, out_index<=ptr, out_valid<=1;
//    - out_last<=(no set bit of mask_q above ptr); go to HOLD.
//  - HOLD:
//    - out_valid, out_index, out_data and out_last are held stable until out_valid&&out_ready.
//    - On handshake with out_last=1: out_valid<=0; go to DONE.
//    - On handshake with out_last=0: out_valid<=0; ptr<=next set bit above ptr; go to SCAN.
//  - DONE: done=1 for exactly one cycle, then IDLE. busy=1 in DONE.
//  - Cadence: one beat per 2 cycles minimum (SCAN + HOLD).
//    - start accepted at edge N -> out_valid first high after edge N+1.
//  - Snapshot semantics: each value is sampled in its SCAN cycle.
//    - Later register-file writes do not alter a beat already in HOLD.
//    - A write to Rk before Rk's SCAN cycle is visible in the dump.
//  - start while busy is ignored; mask changes while busy are ignored.
//  - abort=1 in any non-IDLE state: next edge -> IDLE, out_valid<=0, no done pulse.
//    - abort has priority over a same-cycle handshake or SCAN capture.
//    - abort in IDLE has no effect; abort has priority over start.
//  - Asynchronous reset mid-dump clears all state immediately; no partial beat survives.
//  - The ptr search never wraps. mask_q=0x80 produces a single beat (index 7, out_last=1).
//  - rd_addr is registered (=ptr) and valid in SCAN and HOLD; it is 0 in IDLE and DONE.
// STRUCTURE
//  - Shared package lc3_pkg:
//    - REG_DATA_W=16, REG_ADDR_W=3, NUM_REGS=8;
//    - typedef enum logic [1:0] {DUMP_IDLE, DUMP_SCAN, DUMP_HOLD, DUMP_DONE} dump_state_t.
//  - One sub-module: next_set_bit.
//    - Combinational priority encoder: inputs mask, from_idx, inclusive flag.
//    - Outputs idx and found.
//    - Reused for both the first-bit search and the next-bit search.
// TESTING
//  1. Full dump: R0..R7=0x1000+i, mask=0xFF, out_ready=1.
//     -> 8 beats, index 0..7, data 0x1000..0x1007; last only on R7; done 1 cycle after R7 beat.
//  2. Sparse mask 0x82 with out_ready stalled 5 cycles on the first beat.
//     -> beat (1, R1) held stable for 5 cycles, then beat (7, R7, last=1).
//  3. Empty mask: start with mask=0.
//     -> no out_valid; busy high for 1 cycle; done pulse 1 cycle after start.
//  4. Snapshot: mask=0x03; write R1=0xBEEF while beat R0 is in HOLD.
//     -> beat 1 data=0xBEEF. Write R0=0x5555 during the same HOLD -> beat 0 data unchanged.
//  5. Abort and start: abort asserted in the HOLD of the 3rd beat of mask=0xFF.
//     -> IDLE next cycle, out_valid=0, no done. A following start begins again at R0.
//  6. Async reset mid-SCAN (reset low between edges).
//     -> outputs zero immediately, busy=0. start while busy=1 in other runs is ignored.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 register-file constants and the dump-reader state encoding.
package lc3_pkg;

  localparam int unsigned REG_DATA_W = 16;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned NUM_REGS   = 8;

  typedef enum logic [1:0] {
    DUMP_IDLE,
    DUMP_SCAN,
    DUMP_HOLD,
    DUMP_DONE
  } dump_state_t;

endpackage

// File: rtl/next_set_bit.sv
// Priority encoder: lowest set bit of mask at or above from_idx (inclusive) or
// strictly above it (exclusive). Never wraps past the top bit.
module next_set_bit #(
  parameter int unsigned NUM_REGS = lc3_pkg::NUM_REGS,
  parameter int unsigned ADDR_W   = lc3_pkg::REG_ADDR_W
) (
  input  logic [NUM_REGS-1:0] mask,
  input  logic [ADDR_W-1:0]   from_idx,
  input  logic                inclusive,
  output logic [ADDR_W-1:0]   idx,
  output logic                found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (!found && mask[i] &&
          ((ADDR_W'(i) > from_idx) || (inclusive && (ADDR_W'(i) == from_idx)))) begin
        idx   = ADDR_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks the register file through one read port and streams the masked
// registers as (index, value) beats over a valid/ready interface.
module regfile_dump_reader
  import lc3_pkg::*;
#(
  parameter int unsigned NUM_REGS = lc3_pkg::NUM_REGS,
  parameter int unsigned DATA_W   = lc3_pkg::REG_DATA_W,
  parameter int unsigned ADDR_W   = lc3_pkg::REG_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [NUM_REGS-1:0] mask,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_index,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  dump_state_t r_state, w_next_state;

  logic [NUM_REGS-1:0] r_mask_q;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_out_valid;
  logic [ADDR_W-1:0]   r_out_index;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_last;

  logic [NUM_REGS-1:0] w_search_mask;
  logic [ADDR_W-1:0]   w_search_from;
  logic                w_search_incl;
  logic [ADDR_W-1:0]   w_found_idx;
  logic                w_found;
  logic                w_abort;
  logic                w_handshake;

  // One encoder serves both searches: IDLE looks for the first bit of the
  // incoming mask, SCAN/HOLD look strictly above ptr in the latched mask.
  always_comb begin
    w_search_mask = r_mask_q;
    w_search_from = r_ptr;
    w_search_incl = 1'b0;
    if (r_state == DUMP_IDLE) begin
      w_search_mask = mask;
      w_search_from = '0;
      w_search_incl = 1'b1;
    end
  end

  next_set_bit #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_next_set_bit (
    .mask      (w_search_mask),
    .from_idx  (w_search_from),
    .inclusive (w_search_incl),
    .idx       (w_found_idx),
    .found     (w_found)
  );

  assign w_abort     = abort && (r_state != DUMP_IDLE);
  assign w_handshake = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= DUMP_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (w_abort) begin
      w_next_state = DUMP_IDLE;
    end else begin
      case (r_state)
        DUMP_IDLE: if (start) w_next_state = w_found ? DUMP_SCAN : DUMP_DONE;
        DUMP_SCAN: w_next_state = DUMP_HOLD;
        DUMP_HOLD: if (w_handshake) w_next_state = r_out_last ? DUMP_DONE : DUMP_SCAN;
        DUMP_DONE: w_next_state = DUMP_IDLE;
        default:   w_next_state = DUMP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask_q    <= '0;
      r_ptr       <= '0;
      r_rd_addr   <= '0;
      r_out_valid <= 1'b0;
      r_out_index <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_abort) begin
      r_rd_addr   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        DUMP_IDLE: begin
          if (start && w_found) begin
            r_mask_q  <= mask;
            r_ptr     <= w_found_idx;
            r_rd_addr <= w_found_idx;
          end
        end
        DUMP_SCAN: begin
          r_out_data  <= rd_data;
          r_out_index <= r_ptr;
          r_out_valid <= 1'b1;
          r_out_last  <= !w_found;
        end
        DUMP_HOLD: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_out_last) begin
              r_rd_addr <= '0;
            end else begin
              r_ptr     <= w_found_idx;
              r_rd_addr <= w_found_idx;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_addr   = r_rd_addr;
  assign out_valid = r_out_valid;
  assign out_index = r_out_index;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = (r_state != DUMP_IDLE);
  assign done      = (r_state == DUMP_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural register file.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  mask;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_index;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [15:0] rf [8];
  int tests = 0;
  int fails = 0;

  assign rd_data = rf[rd_addr];

  always #5 clk = ~clk;

  regfile_dump_reader #(
    .NUM_REGS (8),
    .DATA_W   (16),
    .ADDR_W   (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .mask      (mask),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; abort = 1'b0; mask = '0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h1000 + 16'(i);
    step();
    tests++; if ({out_valid, out_last, busy, done} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags got %b exp 0000", {out_valid, out_last, busy, done}); end
    tests++; if ({rd_addr, out_index, out_data} !== 22'd0) begin
      fails++; $display("FAIL reset_values got %h/%h/%h exp 0/0/0", rd_addr, out_index, out_data); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_full_dump();
    mask = 8'hFF; out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    tests++; if ({busy, out_valid, rd_addr} !== {1'b1, 1'b0, 3'd0}) begin
      fails++; $display("FAIL full_scan0 got busy=%b valid=%b addr=%0d exp 1/0/0", busy, out_valid, rd_addr); end
    for (int i = 0; i < 8; i++) begin
      step();
      tests++; if ({out_valid, out_index, out_data, out_last} !== {1'b1, 3'(i), 16'h1000 + 16'(i), (i == 7)}) begin
        fails++; $display("FAIL full_beat%0d got v=%b idx=%0d d=%h l=%b exp 1/%0d/%h/%b",
                          i, out_valid, out_index, out_data, out_last, i, 16'h1000 + 16'(i), (i == 7)); end
      step();
      if (i < 7) begin
        tests++; if ({out_valid, rd_addr, done} !== {1'b0, 3'(i + 1), 1'b0}) begin
          fails++; $display("FAIL full_gap%0d got v=%b addr=%0d done=%b exp 0/%0d/0", i, out_valid, rd_addr, done, i + 1); end
      end
    end
    tests++; if ({done, busy, out_valid, rd_addr} !== {1'b1, 1'b1, 1'b0, 3'd0}) begin
      fails++; $display("FAIL full_done got done=%b busy=%b v=%b addr=%0d exp 1/1/0/0", done, busy, out_valid, rd_addr); end
    step();
    tests++; if ({done, busy} !== 2'b00) begin
      fails++; $display("FAIL full_idle got done=%b busy=%b exp 0/0", done, busy); end
  endtask

  task automatic test_sparse_stall();
    mask = 8'h82; out_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0; mask = 8'hFF;
    tests++; if (rd_addr !== 3'd1) begin
      fails++; $display("FAIL sparse_first_addr got %0d exp 1", rd_addr); end
    step();
    for (int k = 0; k < 5; k++) begin
      tests++; if ({out_valid, out_index, out_data, out_last} !== {1'b1, 3'd1, 16'h1001, 1'b0}) begin
        fails++; $display("FAIL sparse_hold%0d got v=%b idx=%0d d=%h l=%b exp 1/1/1001/0",
                          k, out_valid, out_index, out_data, out_last); end
      if (k < 4) step();
    end
    out_ready = 1'b1;
    step();
    tests++; if ({out_valid, rd_addr} !== {1'b0, 3'd7}) begin
      fails++; $display("FAIL sparse_next_addr got v=%b addr=%0d exp 0/7", out_valid, rd_addr); end
    step();
    tests++; if ({out_valid, out_index, out_data, out_last} !== {1'b1, 3'd7, 16'h1007, 1'b1}) begin
      fails++; $display("FAIL sparse_beat7 got v=%b idx=%0d d=%h l=%b exp 1/7/1007/1", out_valid, out_index, out_data, out_last); end
    step();
    tests++; if (done !== 1'b1) begin
      fails++; $display("FAIL sparse_done got %b exp 1", done); end
    step();
  endtask

  task automatic test_empty_mask();
    mask = 8'h00; start = 1'b1;
    step();
    start = 1'b0;
    tests++; if ({busy, done, out_valid} !== 3'b110) begin
      fails++; $display("FAIL empty_done got busy=%b done=%b v=%b exp 1/1/0", busy, done, out_valid); end
    step();
    tests++; if ({busy, done, out_valid} !== 3'b000) begin
      fails++; $display("FAIL empty_idle got busy=%b done=%b v=%b exp 0/0/0", busy, done, out_valid); end
  endtask

  task automatic test_snapshot();
    rf[0] = 16'h1111; rf[1] = 16'h2222;
    mask = 8'h03; out_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rf[1] = 16'hBEEF; rf[0] = 16'h5555;
    step();
    tests++; if ({out_valid, out_index, out_data} !== {1'b1, 3'd0, 16'h1111}) begin
      fails++; $display("FAIL snap_beat0 got v=%b idx=%0d d=%h exp 1/0/1111", out_valid, out_index, out_data); end
    out_ready = 1'b1;
    step();
    step();
    tests++; if ({out_valid, out_index, out_data, out_last} !== {1'b1, 3'd1, 16'hBEEF, 1'b1}) begin
      fails++; $display("FAIL snap_beat1 got v=%b idx=%0d d=%h l=%b exp 1/1/beef/1", out_valid, out_index, out_data, out_last); end
    step();
    step();
    for (int i = 0; i < 8; i++) rf[i] = 16'h1000 + 16'(i);
  endtask

  task automatic test_abort_restart();
    mask = 8'hFF; out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    tests++; if ({out_valid, out_index} !== {1'b1, 3'd2}) begin
      fails++; $display("FAIL abort_pre got v=%b idx=%0d exp 1/2", out_valid, out_index); end
    abort = 1'b1; start = 1'b1; mask = 8'h80;
    step();
    abort = 1'b0; start = 1'b0;
    tests++; if ({busy, out_valid, done, rd_addr} !== {1'b0, 1'b0, 1'b0, 3'd0}) begin
      fails++; $display("FAIL abort_idle got busy=%b v=%b done=%b addr=%0d exp 0/0/0/0", busy, out_valid, done, rd_addr); end
    step();
    tests++; if ({busy, done} !== 2'b00) begin
      fails++; $display("FAIL abort_nodone got busy=%b done=%b exp 0/0", busy, done); end
    mask = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    step();
    tests++; if ({out_valid, out_index, out_data} !== {1'b1, 3'd0, 16'h1000}) begin
      fails++; $display("FAIL restart_beat0 got v=%b idx=%0d d=%h exp 1/0/1000", out_valid, out_index, out_data); end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_start_ignored();
    mask = 8'h01; out_ready = 1'b0; start = 1'b1;
    step();
    step();
    mask = 8'h80;
    step();
    start = 1'b0;
    tests++; if ({out_valid, out_index, out_last} !== {1'b1, 3'd0, 1'b1}) begin
      fails++; $display("FAIL ignore_beat got v=%b idx=%0d l=%b exp 1/0/1", out_valid, out_index, out_last); end
    out_ready = 1'b1;
    step();
    tests++; if ({done, out_valid} !== 2'b10) begin
      fails++; $display("FAIL ignore_done got done=%b v=%b exp 1/0", done, out_valid); end
    step();
  endtask

  task automatic test_async_reset();
    rf[1] = 16'hCAFE;
    mask = 8'hFF; out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    tests++; if ({busy, rd_addr, out_data} !== {1'b1, 3'd1, 16'h1000}) begin
      fails++; $display("FAIL areset_pre got busy=%b addr=%0d d=%h exp 1/1/1000", busy, rd_addr, out_data); end
    #2 reset = 1'b0;
    #1;
    tests++; if ({busy, done, out_valid, out_last, rd_addr, out_index, out_data} !== 26'd0) begin
      fails++; $display("FAIL areset_clear got busy=%b v=%b addr=%0d idx=%0d d=%h exp all 0",
                        busy, out_valid, rd_addr, out_index, out_data); end
    step();
    reset = 1'b1;
    mask = 8'h02; start = 1'b1;
    step();
    start = 1'b0;
    step();
    tests++; if ({out_valid, out_index, out_data, out_last} !== {1'b1, 3'd1, 16'hCAFE, 1'b1}) begin
      fails++; $display("FAIL areset_after got v=%b idx=%0d d=%h l=%b exp 1/1/cafe/1", out_valid, out_index, out_data, out_last); end
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_sparse_stall();
    test_empty_mask();
    test_snapshot();
    test_abort_restart();
    test_start_ignored();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
